// File: rtl/cop0_irq_if.sv
// cop0_irq_if: MTC0/MFC0 bus between the scalar pipeline and coprocessor 0.
// The master is the pipeline stage and the slave is the coprocessor.
interface cop0_irq_if;
  logic [4:0]  read_addr;
  logic        tocpu_en;
  logic [31:0] tocpu;
  logic        stalled;
  logic [4:0]  dest_addr;
  logic [31:0] fromcpu;
  logic        fromcpu_en;

  modport master (
    output read_addr, tocpu_en, dest_addr, fromcpu, fromcpu_en,
    input  tocpu, stalled
  );

  modport slave (
    input  read_addr, tocpu_en, dest_addr, fromcpu, fromcpu_en,
    output tocpu, stalled
  );
endinterface

// File: rtl/cop0_irq.sv
// cop0_irq: coprocessor 0 for the scalar core. It holds Status, Cause, EPC,
// BadVAddr, an optional Count/Compare timer and PRId. It takes interrupts and
// synchronous exceptions, handles ERET, and runs the single-stall MFC0 handshake.
module cop0_irq #(
  parameter int unsigned NUM_IRQ  = 6,
  parameter int unsigned TIMER_EN = 1,
  parameter logic [31:0] PRID     = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               resetn,
  cop0_irq_if.slave          bus,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        epc_in,
  input  logic [31:0]        badvaddr_in,
  input  logic               badvaddr_we,
  input  logic               eret,
  output logic               exception,
  output logic [31:0]        status
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic       TIMER_ON      = (TIMER_EN != 0);

  state_t      state_q;
  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] tocpu_q;
  logic [5:0]  cause_hw_q;
  logic [1:0]  cause_sw_q;
  logic [4:0]  exc_code_q;
  logic        timer_pend_q;

  logic [5:0]  irq_ext;
  logic        timer_pend;
  logic [7:0]  cause_ip;
  logic [31:0] cause_word;
  logic        int_take;
  logic        take;
  logic        wr_badvaddr;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] rd_data;

  // Widen the interrupt lines to the six Cause IP slots; missing lines read 0.
  always_comb begin
    irq_ext = '0;
    irq_ext[NUM_IRQ-1:0] = irq;
  end

  assign timer_pend = TIMER_ON & timer_pend_q;
  assign cause_ip   = {cause_hw_q[5] | timer_pend, cause_hw_q[4:0], cause_sw_q};
  assign cause_word = {16'h0000, cause_ip, 1'b0, exc_code_q, 2'b00};
  assign int_take   = status_q[0] & (|(cause_ip & status_q[15:8]));
  assign take       = resetn & (exc_req | int_take);

  assign exception   = take;
  assign status      = status_q;
  assign bus.tocpu   = tocpu_q;
  assign bus.stalled = resetn & bus.tocpu_en & (state_q == IDLE);

  assign wr_badvaddr = bus.fromcpu_en && (bus.dest_addr == ADDR_BADVADDR);
  assign wr_count    = bus.fromcpu_en && (bus.dest_addr == ADDR_COUNT);
  assign wr_compare  = bus.fromcpu_en && (bus.dest_addr == ADDR_COMPARE);
  assign wr_status   = bus.fromcpu_en && (bus.dest_addr == ADDR_STATUS);
  assign wr_cause    = bus.fromcpu_en && (bus.dest_addr == ADDR_CAUSE);
  assign wr_epc      = bus.fromcpu_en && (bus.dest_addr == ADDR_EPC);

  // MFC0 register select; the timer registers read 0 when the timer is absent.
  always_comb begin
    rd_data = '0;
    case (bus.read_addr)
      ADDR_BADVADDR: rd_data = badvaddr_q;
      ADDR_COUNT:    rd_data = TIMER_ON ? count_q : 32'h0;
      ADDR_COMPARE:  rd_data = TIMER_ON ? compare_q : 32'h0;
      ADDR_STATUS:   rd_data = status_q;
      ADDR_CAUSE:    rd_data = cause_word;
      ADDR_EPC:      rd_data = epc_q;
      ADDR_PRID:     rd_data = PRID;
      default:       rd_data = '0;
    endcase
  end

  // Architectural registers; an MTC0 to a register beats every other update to it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= '0;
      cause_hw_q <= '0;
      cause_sw_q <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      cause_hw_q <= irq_ext;
      if (wr_status) begin
        status_q <= bus.fromcpu;
      end else if (take) begin
        status_q[5:0] <= {status_q[3:0], 2'b00};
      end else if (eret) begin
        status_q[5:0] <= {status_q[5:4], status_q[5:2]};
      end
      if (wr_cause) begin
        cause_sw_q <= bus.fromcpu[9:8];
      end else if (take) begin
        exc_code_q <= exc_req ? exc_code : 5'd0;
      end
      if (wr_epc) begin
        epc_q <= bus.fromcpu;
      end else if (take) begin
        epc_q <= epc_in;
      end
      if (wr_badvaddr) begin
        badvaddr_q <= bus.fromcpu;
      end else if (badvaddr_we) begin
        badvaddr_q <= badvaddr_in;
      end
    end
  end

  // Free-running Count with a sticky match flag that a Compare write clears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      compare_q    <= 32'hFFFF_FFFF;
      timer_pend_q <= 1'b0;
    end else if (TIMER_ON) begin
      count_q <= wr_count ? bus.fromcpu : count_q + 32'd1;
      if (wr_compare) begin
        compare_q <= bus.fromcpu;
      end
      if (wr_compare) begin
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  // One-cycle MFC0 stall handshake and the registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tocpu_q <= '0;
    end else begin
      tocpu_q <= rd_data;
      case (state_q)
        IDLE:    state_q <= bus.tocpu_en ? WAIT : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
